alb_mss_fab_ahbl_slv_mux: RTL and testbench
===========================================

Name: alb_mss_fab_ahbl_slv_mux

Overview:
AHB-Lite slave-side interconnect stage that sits directly downstream of the IBP-to-AHB-Lite select bridge. It consumes the bridge's one-hot HSEL, HTRANS and broadcast HREADY, and forwards select and HREADY to L_W slaves. It tracks which slave owns the current data phase and muxes that slave's HREADYOUT, HRESP and HRDATA back to the bridge. A built-in default slave returns the two-cycle AHB ERROR response for unmapped or illegal (multi-hot) selects.

Parameters:
L_W, 4, number of slave ports; each slave is selected by one HSEL bit, range 1..32
DATA_W, 64, data width; legal values are 32, 64 and 128

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_a  in  1  reset, synchronous, active-high
bus_clk_en  in  1  clock enable for N:1 bus ratios; state advances only when this is high
m_hsel  in  L_W  one-hot slave select from the bridge, address phase
m_htrans  in  2  transfer type: IDLE=00, BUSY=01, NSEQ=10, SEQ=11
m_hready_resp  out  1  muxed HREADY returned to the bridge
m_hresp  out  1  muxed response: 0=OKAY, 1=ERROR
m_hrdata  out  DATA_W  muxed read data
s_hsel  out  L_W  gated select to slaves
s_hready  out  1  broadcast HREADY to all slaves; equals m_hready_resp
s_hreadyout  in  L_W  per-slave HREADYOUT
s_hresp  in  L_W  per-slave HRESP
s_hrdata  in  L_W*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W]

Behaviour:
- onehot = m_hsel has exactly one bit set.
- dec_err = m_htrans[1] & ~onehot.
- s_hsel = onehot ? m_hsel : 0. A multi-hot select never reaches any slave.
- addr_accept = bus_clk_en & m_hready_resp.
- Data-phase select register dsel[L_W-1:0], updated on addr_accept:
  - m_htrans = NSEQ/SEQ with onehot: dsel <= m_hsel.
  - Otherwise (IDLE, BUSY, or dec_err): dsel <= 0.
  - No addr_accept: dsel holds.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 on addr_accept & dec_err.
  - DS_ERR1 -> DS_ERR2 when bus_clk_en.
  - DS_ERR2 -> DS_ERR1 on addr_accept & dec_err; -> DS_IDLE on any other addr_accept; otherwise holds.
  - Transitions only occur when bus_clk_en is high.
- Output mux (combinational from registered state; zero added latency):
  - DS_ERR1: hready_resp=0, hresp=1, hrdata=0.
  - DS_ERR2: hready_resp=1, hresp=1, hrdata=0.
  - dsel bit i set: hready_resp=s_hreadyout[i], hresp=s_hresp[i], hrdata=slice i.
  - Otherwise (idle or BUSY data phase): hready_resp=1, hresp=0, hrdata=0.
- HREADYOUT, HRESP and HRDATA of non-owning slaves are ignored.
- Pipelining: a new address is accepted in the same cycle the previous data phase completes. Back-to-back transfers to different slaves have no bubble.
- The master may change HTRANS to IDLE during DS_ERR1. This is legal; the new value is sampled in DS_ERR2.
- bus_clk_en low: dsel and FSM hold; outputs stay stable.
- Reset (rst_a high at a clock edge, regardless of bus_clk_en): dsel=0, FSM=DS_IDLE.
  - Outputs after reset: m_hready_resp=1, m_hresp=0, m_hrdata=0, s_hready=1.
  - Reset mid-transfer abandons the data phase with no further response.
- s_hready = m_hready_resp at all times.

Test Plan:
1. Reset: hold rst_a 2 cycles with garbage inputs -> m_hready_resp=1, m_hresp=0, m_hrdata=0, dsel=0, FSM=DS_IDLE.
2. Wait-state read: NSEQ, m_hsel=4'b0100; s_hreadyout[2] = 0,0,1; slice2 = 64'hDEADBEEF01234567 -> m_hready_resp low for 2 cycles, then high with that data and m_hresp=0.
3. Pipelined transfers: NSEQ to slave0, then NSEQ to slave3 while slave0 completes zero-wait -> data phases muxed from slave0 then slave3 on consecutive cycles, no idle cycle between them.
4. Unmapped select: NSEQ with m_hsel=0 -> {hready,hresp} = {0,1} then {1,1}; next transfer is IDLE -> {1,0}.
5. Multi-hot select: NSEQ with m_hsel=4'b0011 -> s_hsel=0 and the same two-cycle ERROR response; slave0 and slave1 see no select.
6. Clock enable and reset: bus_clk_en toggling 1,0,1,0 during the error sequence -> each error state lasts 2 clk cycles; assert rst_a in DS_ERR1 -> next cycle {hready,hresp} = {1,0}, FSM=DS_IDLE.

Source files
------------

// File: rtl/alb_mss_fab_ahbl_slv_mux.sv
// AHB-Lite slave-side mux: forwards one-hot selects to L_W slaves, tracks the
// data-phase owner and returns its response; a default slave answers bad selects.
module alb_mss_fab_ahbl_slv_mux #(
    parameter int L_W    = 4,
    parameter int DATA_W = 64
) (
    input  logic                    clk,
    input  logic                    rst_a,
    input  logic                    bus_clk_en,
    input  logic [L_W-1:0]          m_hsel,
    input  logic [1:0]              m_htrans,
    output logic                    m_hready_resp,
    output logic                    m_hresp,
    output logic [DATA_W-1:0]       m_hrdata,
    output logic [L_W-1:0]          s_hsel,
    output logic                    s_hready,
    input  logic [L_W-1:0]          s_hreadyout,
    input  logic [L_W-1:0]          s_hresp,
    input  logic [L_W*DATA_W-1:0]   s_hrdata
);

    localparam logic [1:0] HT_NSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ  = 2'b11;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    ds_state_t         ds_state_reg;
    ds_state_t         ds_state_next;
    logic [L_W-1:0]    dsel_reg;
    logic [L_W-1:0]    dsel_next;

    logic              onehot;
    logic              trans_active;
    logic              dec_err;
    logic              addr_accept;

    logic              slv_hready;
    logic              slv_hresp;
    logic [DATA_W-1:0] slv_hrdata;
    logic [DATA_W-1:0] rdata_masked [L_W];

    // Power-of-two test: exactly one bit set
    assign onehot       = (m_hsel != '0) && ((m_hsel & (m_hsel - L_W'(1))) == '0);
    assign trans_active = (m_htrans == HT_NSEQ) || (m_htrans == HT_SEQ);
    assign dec_err      = trans_active & ~onehot;
    assign addr_accept  = bus_clk_en & m_hready_resp;

    assign s_hsel   = onehot ? m_hsel : '0;
    assign s_hready = m_hready_resp;

    always_comb begin
        dsel_next = dsel_reg;
        if (addr_accept) begin
            dsel_next = (trans_active && onehot) ? m_hsel : '0;
        end
    end

    always_comb begin
        ds_state_next = ds_state_reg;
        case (ds_state_reg)
            DS_IDLE: begin
                if (addr_accept && dec_err) ds_state_next = DS_ERR1;
            end
            DS_ERR1: begin
                if (bus_clk_en) ds_state_next = DS_ERR2;
            end
            DS_ERR2: begin
                if (addr_accept) ds_state_next = dec_err ? DS_ERR1 : DS_IDLE;
            end
            default: ds_state_next = DS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            dsel_reg     <= '0;
            ds_state_reg <= DS_IDLE;
        end else begin
            dsel_reg     <= dsel_next;
            ds_state_reg <= ds_state_next;
        end
    end

    // AND-OR mux; dsel is one-hot or zero, so non-owners contribute nothing
    genvar gi;
    generate
        for (gi = 0; gi < L_W; gi++) begin : g_rdata_mask
            assign rdata_masked[gi] = dsel_reg[gi] ? s_hrdata[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        slv_hrdata = '0;
        for (int i = 0; i < L_W; i++) begin
            slv_hrdata = slv_hrdata | rdata_masked[i];
        end
    end

    assign slv_hready = ~|(dsel_reg & ~s_hreadyout);
    assign slv_hresp  =  |(dsel_reg &  s_hresp);

    always_comb begin
        m_hready_resp = 1'b1;
        m_hresp       = 1'b0;
        m_hrdata      = '0;
        case (ds_state_reg)
            DS_ERR1: begin
                m_hready_resp = 1'b0;
                m_hresp       = 1'b1;
            end
            DS_ERR2: begin
                m_hready_resp = 1'b1;
                m_hresp       = 1'b1;
            end
            default: begin
                m_hready_resp = slv_hready;
                m_hresp       = slv_hresp;
                m_hrdata      = slv_hrdata;
            end
        endcase
    end

endmodule

// File: tb/tb_alb_mss_fab_ahbl_slv_mux.sv
// Directed bench for alb_mss_fab_ahbl_slv_mux: wait states, pipelining,
// default-slave errors, clock enable and reset.
module tb_alb_mss_fab_ahbl_slv_mux;

    localparam int L_W    = 4;
    localparam int DATA_W = 64;

    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [1:0] HT_BUSY = 2'b01;
    localparam logic [1:0] HT_NSEQ = 2'b10;

    logic                  clk = 1'b0;
    logic                  rst_a;
    logic                  bus_clk_en;
    logic [L_W-1:0]        m_hsel;
    logic [1:0]            m_htrans;
    logic                  m_hready_resp;
    logic                  m_hresp;
    logic [DATA_W-1:0]     m_hrdata;
    logic [L_W-1:0]        s_hsel;
    logic                  s_hready;
    logic [L_W-1:0]        s_hreadyout;
    logic [L_W-1:0]        s_hresp;
    logic [L_W*DATA_W-1:0] s_hrdata;

    int check_cnt = 0;
    int error_cnt = 0;

    alb_mss_fab_ahbl_slv_mux #(.L_W(L_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst_a         (rst_a),
        .bus_clk_en    (bus_clk_en),
        .m_hsel        (m_hsel),
        .m_htrans      (m_htrans),
        .m_hready_resp (m_hready_resp),
        .m_hresp       (m_hresp),
        .m_hrdata      (m_hrdata),
        .s_hsel        (s_hsel),
        .s_hready      (s_hready),
        .s_hreadyout   (s_hreadyout),
        .s_hresp       (s_hresp),
        .s_hrdata      (s_hrdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after new inputs, then compare
    task automatic check_resp(input string tag, input logic exp_rdy, input logic exp_resp,
                              input logic [DATA_W-1:0] exp_data);
        #1;
        check({tag, ".hready"}, m_hready_resp, exp_rdy);
        check({tag, ".hresp"},  m_hresp,       exp_resp);
        check({tag, ".hrdata"}, m_hrdata,      exp_data);
        check({tag, ".s_hready"}, s_hready,    exp_rdy);
        $display("txn %-12s hready=%0b hresp=%0b hrdata=%h s_hsel=%b",
                 tag, m_hready_resp, m_hresp, m_hrdata, s_hsel);
    endtask

    task automatic set_slice(input int idx, input logic [DATA_W-1:0] val);
        s_hrdata[idx*DATA_W +: DATA_W] = val;
    endtask

    initial begin
        // 1. reset with garbage inputs
        rst_a       = 1'b1;
        bus_clk_en  = 1'b1;
        m_hsel      = 4'b1011;
        m_htrans    = HT_NSEQ;
        s_hreadyout = 4'b0000;
        s_hresp     = 4'b1111;
        s_hrdata    = {4{64'hA5A5_5A5A_F00D_CAFE}};
        step();
        step();
        check_resp("reset", 1'b1, 1'b0, '0);
        check("reset.s_hsel_multihot", s_hsel, 4'b0000);
        rst_a    = 1'b0;
        m_htrans = HT_IDLE;
        m_hsel   = 4'b0000;
        s_hresp  = 4'b0000;
        step();
        check_resp("post_reset", 1'b1, 1'b0, '0);

        // 2. wait-state read from slave 2
        m_htrans    = HT_NSEQ;
        m_hsel      = 4'b0100;
        s_hreadyout = 4'b1111;
        #1;
        check("ws.s_hsel", s_hsel, 4'b0100);
        step();
        m_htrans    = HT_IDLE;
        m_hsel      = 4'b0000;
        s_hreadyout = 4'b1011;
        s_hresp     = 4'b1011;
        set_slice(2, 64'hDEAD_BEEF_0123_4567);
        check_resp("ws.wait1", 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567);
        step();
        check_resp("ws.wait2", 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567);
        s_hreadyout = 4'b0100;
        check_resp("ws.done", 1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567);
        step();
        check_resp("ws.idle", 1'b1, 1'b0, '0);

        // 3. pipelined slave0 then slave3
        s_hresp     = 4'b0000;
        s_hreadyout = 4'b1111;
        set_slice(0, 64'h1111_2222_3333_4444);
        set_slice(3, 64'h9999_8888_7777_6666);
        m_htrans = HT_NSEQ;
        m_hsel   = 4'b0001;
        step();
        m_hsel   = 4'b1000;
        check_resp("pipe.s0", 1'b1, 1'b0, 64'h1111_2222_3333_4444);
        check("pipe.s_hsel3", s_hsel, 4'b1000);
        step();
        m_htrans = HT_BUSY;
        m_hsel   = 4'b0000;
        check_resp("pipe.s3", 1'b1, 1'b0, 64'h9999_8888_7777_6666);
        step();
        m_htrans = HT_IDLE;
        check_resp("pipe.busy", 1'b1, 1'b0, '0);

        // 4. unmapped select
        m_htrans = HT_NSEQ;
        m_hsel   = 4'b0000;
        step();
        m_htrans = HT_IDLE;
        check_resp("unmap.err1", 1'b0, 1'b1, '0);
        step();
        check_resp("unmap.err2", 1'b1, 1'b1, '0);
        step();
        check_resp("unmap.idle", 1'b1, 1'b0, '0);

        // 5. multi-hot select, held into a second error sequence
        m_htrans = HT_NSEQ;
        m_hsel   = 4'b0011;
        #1;
        check("multi.s_hsel", s_hsel, 4'b0000);
        step();
        check_resp("multi.err1", 1'b0, 1'b1, '0);
        check("multi.s_hsel_e1", s_hsel, 4'b0000);
        step();
        check_resp("multi.err2", 1'b1, 1'b1, '0);
        step();
        m_htrans = HT_IDLE;
        m_hsel   = 4'b0000;
        check_resp("multi.err1b", 1'b0, 1'b1, '0);
        step();
        check_resp("multi.err2b", 1'b1, 1'b1, '0);
        step();
        check_resp("multi.idle", 1'b1, 1'b0, '0);

        // 6a. no capture while bus_clk_en is low
        bus_clk_en = 1'b0;
        m_htrans   = HT_NSEQ;
        m_hsel     = 4'b0010;
        step();
        m_htrans    = HT_IDLE;
        m_hsel      = 4'b0000;
        bus_clk_en  = 1'b1;
        s_hreadyout = 4'b1101;
        check_resp("cen.nocap", 1'b1, 1'b0, '0);
        s_hreadyout = 4'b1111;

        // 6b. error sequence with enable toggling 1,0,1,0
        m_htrans = HT_NSEQ;
        step();
        m_htrans   = HT_IDLE;
        bus_clk_en = 1'b0;
        check_resp("cen.err1a", 1'b0, 1'b1, '0);
        step();
        bus_clk_en = 1'b1;
        check_resp("cen.err1b", 1'b0, 1'b1, '0);
        step();
        bus_clk_en = 1'b0;
        check_resp("cen.err2a", 1'b1, 1'b1, '0);
        step();
        bus_clk_en = 1'b1;
        check_resp("cen.err2b", 1'b1, 1'b1, '0);
        step();
        check_resp("cen.idle", 1'b1, 1'b0, '0);

        // 6c. reset while in DS_ERR1, with enable low
        m_htrans = HT_NSEQ;
        m_hsel   = 4'b0000;
        step();
        check_resp("rst.err1", 1'b0, 1'b1, '0);
        rst_a      = 1'b1;
        bus_clk_en = 1'b0;
        step();
        rst_a      = 1'b0;
        bus_clk_en = 1'b1;
        m_htrans   = HT_IDLE;
        check_resp("rst.idle", 1'b1, 1'b0, '0);
        step();
        check_resp("rst.stay", 1'b1, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
